// File: rtl/spc700_seq_pkg.sv
// Shared spc700 types: microcode stateCtrl encoding, sequencer FSM states,
// and extended-phase lengths for MUL/DIV.
package spc700_seq_pkg;

  typedef enum logic [1:0] {
    SC_NEXT   = 2'd0,
    SC_END    = 2'd1,
    SC_BRANCH = 2'd2,
    SC_EXT    = 2'd3
  } StateCtrl_t;

  typedef enum logic [1:0] {
    SEQ_RUN  = 2'd0,
    SEQ_EXT  = 2'd1,
    SEQ_HALT = 2'd2
  } SeqState_t;

  localparam int EXT_LEN_MUL = 4;
  localparam int EXT_LEN_DIV = 8;

endpackage

// File: rtl/spc700_seq_if.sv
// Sequencer bus: bus-interface/decoder side is master, sequencer is slave.
// Control inputs are sampled on enabled edges; outputs are registered except LAST_CYCLE.
interface spc700_seq_if;
  logic        EN;
  logic [1:0]  STATE_CTRL;
  logic        COND;
  logic [7:0]  DBUS;
  logic        HALT_REQ;
  logic [7:0]  IR;
  logic [3:0]  STATE;
  logic        LAST_CYCLE;
  logic        EXT_BUSY;
  logic        HALTED;
  logic [15:0] RETIRED;

  modport master (
    output EN, STATE_CTRL, COND, DBUS, HALT_REQ,
    input  IR, STATE, LAST_CYCLE, EXT_BUSY, HALTED, RETIRED
  );

  modport slave (
    input  EN, STATE_CTRL, COND, DBUS, HALT_REQ,
    output IR, STATE, LAST_CYCLE, EXT_BUSY, HALTED, RETIRED
  );
endinterface

// File: rtl/spc700_seq.sv
// SPC700 (IR, STATE) sequencer with MUL/DIV extended phase and STOP/SLEEP halt.
// Latency: IR/STATE update on the enabled edge, LAST_CYCLE is combinational; backpressure: EN=0 holds all state.
module spc700_seq
  import spc700_seq_pkg::*;
#(
  parameter logic [7:0] RST_IR = 8'h00,
  parameter logic [7:0] MUL_OP = 8'hCF,
  parameter logic [7:0] DIV_OP = 8'h9E
) (
  input logic        CLK,
  input logic        RST_N,
  spc700_seq_if.slave bus
);

  localparam logic [1:0] S_RUN  = SEQ_RUN;
  localparam logic [1:0] S_EXT  = SEQ_EXT;
  localparam logic [1:0] S_HALT = SEQ_HALT;

  logic [1:0]  fsm_q;
  logic [7:0]  ir_q;
  logic [3:0]  state_q;
  logic        ext_busy_q;
  logic        halted_q;
  logic [15:0] retired_q;
  logic [2:0]  ext_cnt_q;
  logic [2:0]  saved_q;

  StateCtrl_t  sc;
  logic [2:0]  step;
  logic        ext_op;
  logic        go_next;
  logic        finish;
  logic        start_ext;
  logic        ext_last;
  logic [2:0]  ext_cnt_inc;

  assign sc = StateCtrl_t'(bus.STATE_CTRL);

  always_comb begin
    step        = state_q[2:0];
    ext_op      = (ir_q == MUL_OP) || (ir_q == DIV_OP);
    go_next     = (sc == SC_NEXT) || ((sc == SC_BRANCH) && bus.COND) || ((sc == SC_EXT) && !ext_op);
    // Advancing past step 7 has no next microstep, so it retires the instruction.
    finish      = (sc == SC_END) || ((sc == SC_BRANCH) && !bus.COND) || (go_next && (step == 3'd7));
    start_ext   = (sc == SC_EXT) && ext_op;
    ext_cnt_inc = ext_cnt_q + 3'd1;
    ext_last    = (ir_q == DIV_OP) ? (ext_cnt_q == 3'(EXT_LEN_DIV - 1))
                                   : (ext_cnt_q == 3'(EXT_LEN_MUL - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fsm_q      <= S_RUN;
      ir_q       <= RST_IR;
      state_q    <= 4'h0;
      ext_busy_q <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= 16'h0000;
      ext_cnt_q  <= 3'd0;
      saved_q    <= 3'd0;
    end else if (bus.EN) begin
      case (fsm_q)
        S_RUN: begin
          if (bus.HALT_REQ) begin
            fsm_q    <= S_HALT;
            halted_q <= 1'b1;
          end else if (finish) begin
            ir_q      <= bus.DBUS;
            state_q   <= 4'h0;
            retired_q <= retired_q + 16'd1;
          end else if (start_ext) begin
            fsm_q      <= S_EXT;
            saved_q    <= step;
            state_q    <= 4'h8;
            ext_cnt_q  <= 3'd0;
            ext_busy_q <= 1'b1;
          end else begin
            state_q <= {1'b0, step + 3'd1};
          end
        end
        S_EXT: begin
          // Return to the step after the EXT microinstruction for writeback.
          if (ext_last) begin
            fsm_q      <= S_RUN;
            state_q    <= {1'b0, saved_q + 3'd1};
            ext_busy_q <= 1'b0;
          end else begin
            ext_cnt_q <= ext_cnt_inc;
            state_q   <= {2'b10, ext_cnt_inc[1:0]};
          end
        end
        S_HALT: fsm_q <= S_HALT;
        default: fsm_q <= S_RUN;
      endcase
    end
  end

  assign bus.IR         = ir_q;
  assign bus.STATE      = state_q;
  assign bus.EXT_BUSY   = ext_busy_q;
  assign bus.HALTED     = halted_q;
  assign bus.RETIRED    = retired_q;
  assign bus.LAST_CYCLE = bus.EN && (fsm_q == S_RUN) && !bus.HALT_REQ && finish;

endmodule

// File: tb/tb_spc700_seq.sv
// Directed bench for spc700_seq: fetch, branch, MUL/DIV extended phase, halt, reset, RETIRED wrap.
module tb_spc700_seq;

  localparam logic [1:0] NX = 2'd0;
  localparam logic [1:0] EN_D = 2'd1;
  localparam logic [1:0] BR = 2'd2;
  localparam logic [1:0] EX = 2'd3;

  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

  spc700_seq_if bus();

  spc700_seq #(.RST_IR(8'h00), .MUL_OP(8'hCF), .DIV_OP(8'h9E)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] sc, input logic cond,
                       input logic [7:0] d, input logic h);
    bus.EN         = en;
    bus.STATE_CTRL = sc;
    bus.COND       = cond;
    bus.DBUS       = d;
    bus.HALT_REQ   = h;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] seq_mul [3];
    logic [3:0] seq_div [6];
    logic       busy_div [6];
    checks   = 0;
    failures = 0;
    seq_mul  = '{4'd9, 4'd10, 4'd11};
    seq_div  = '{4'd11, 4'd8, 4'd9, 4'd10, 4'd11, 4'd3};
    busy_div = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    RST_N = 1'b0;
    drive(1'b0, NX, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
    chk("rst_ir", 16'(bus.IR), 16'h00);
    chk("rst_state", 16'(bus.STATE), 16'h0);
    chk("rst_retired", bus.RETIRED, 16'h0000);
    chk("rst_busy", 16'(bus.EXT_BUSY), 16'h0);
    chk("rst_halted", 16'(bus.HALTED), 16'h0);

    // END fetches E8
    drive(1'b1, EN_D, 1'b0, 8'hE8, 1'b0);
    chk("end_last", 16'(bus.LAST_CYCLE), 16'h1);
    tick();
    chk("end_ir", 16'(bus.IR), 16'hE8);
    chk("end_state", 16'(bus.STATE), 16'h0);
    chk("end_retired", bus.RETIRED, 16'd1);
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    chk("next_last", 16'(bus.LAST_CYCLE), 16'h0);

    // BRANCH not taken at step 1 with IR=F0
    drive(1'b1, EN_D, 1'b0, 8'hF0, 1'b0);
    tick();
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("br_pre_state", 16'(bus.STATE), 16'h1);
    drive(1'b1, BR, 1'b0, 8'hA5, 1'b0);
    chk("br0_last", 16'(bus.LAST_CYCLE), 16'h1);
    tick();
    chk("br0_ir", 16'(bus.IR), 16'hA5);
    chk("br0_state", 16'(bus.STATE), 16'h0);
    chk("br0_retired", bus.RETIRED, 16'd3);

    // BRANCH taken at step 1 with IR=F0
    drive(1'b1, EN_D, 1'b0, 8'hF0, 1'b0);
    tick();
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b1, BR, 1'b1, 8'hA5, 1'b0);
    chk("br1_last", 16'(bus.LAST_CYCLE), 16'h0);
    tick();
    chk("br1_ir", 16'(bus.IR), 16'hF0);
    chk("br1_state", 16'(bus.STATE), 16'h2);
    chk("br1_retired", bus.RETIRED, 16'd4);

    // MUL: EXT at step 2, HALT_REQ held during the phase must be ignored
    drive(1'b1, EN_D, 1'b0, 8'hCF, 1'b0);
    tick();
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    drive(1'b1, EX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("mul_s8", 16'(bus.STATE), 16'h8);
    chk("mul_busy8", 16'(bus.EXT_BUSY), 16'h1);
    drive(1'b1, EN_D, 1'b1, 8'h77, 1'b1);
    chk("mul_last_ext", 16'(bus.LAST_CYCLE), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mul_s%0d", seq_mul[i]), 16'(bus.STATE), 16'(seq_mul[i]));
      chk("mul_busy", 16'(bus.EXT_BUSY), 16'h1);
    end
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("mul_ret_state", 16'(bus.STATE), 16'h3);
    chk("mul_ret_busy", 16'(bus.EXT_BUSY), 16'h0);
    chk("mul_no_halt", 16'(bus.HALTED), 16'h0);
    chk("mul_ir", 16'(bus.IR), 16'hCF);
    chk("mul_retired", bus.RETIRED, 16'd5);

    // DIV with a 3-cycle EN gap at STATE=10
    drive(1'b1, EN_D, 1'b0, 8'h9E, 1'b0);
    tick();
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    drive(1'b1, EX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("div_s8", 16'(bus.STATE), 16'h8);
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("div_s9", 16'(bus.STATE), 16'h9);
    tick();
    chk("div_s10", 16'(bus.STATE), 16'hA);
    drive(1'b0, NX, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("div_hold_state", 16'(bus.STATE), 16'hA);
      chk("div_hold_busy", 16'(bus.EXT_BUSY), 16'h1);
    end
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("div_seq%0d", i), 16'(bus.STATE), 16'(seq_div[i]));
      chk($sformatf("div_busy%0d", i), 16'(bus.EXT_BUSY), 16'(busy_div[i]));
    end
    chk("div_retired", bus.RETIRED, 16'd6);

    // EXT on a non-MUL/DIV opcode is a plain NEXT
    drive(1'b1, EN_D, 1'b0, 8'hBC, 1'b0);
    tick();
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b1, EX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("bc_state", 16'(bus.STATE), 16'h2);
    chk("bc_busy", 16'(bus.EXT_BUSY), 16'h0);

    // NEXT at step 7 retires
    drive(1'b1, NX, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("s7_state", 16'(bus.STATE), 16'h7);
    drive(1'b1, NX, 1'b0, 8'h3C, 1'b0);
    chk("s7_last", 16'(bus.LAST_CYCLE), 16'h1);
    tick();
    chk("s7_ir", 16'(bus.IR), 16'h3C);
    chk("s7_state0", 16'(bus.STATE), 16'h0);
    chk("s7_retired", bus.RETIRED, 16'd8);

    // HALT_REQ wins over END
    drive(1'b1, EN_D, 1'b0, 8'h11, 1'b1);
    chk("halt_last", 16'(bus.LAST_CYCLE), 16'h0);
    tick();
    chk("halt_halted", 16'(bus.HALTED), 16'h1);
    chk("halt_ir", 16'(bus.IR), 16'h3C);
    drive(1'b1, EN_D, 1'b0, 8'h22, 1'b0);
    chk("halt_last2", 16'(bus.LAST_CYCLE), 16'h0);
    tick();
    drive(1'b0, EN_D, 1'b0, 8'h22, 1'b0);
    tick();
    drive(1'b1, EN_D, 1'b0, 8'h22, 1'b0);
    tick();
    chk("halt_hold_ir", 16'(bus.IR), 16'h3C);
    chk("halt_hold_ret", bus.RETIRED, 16'd8);
    chk("halt_hold_h", 16'(bus.HALTED), 16'h1);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("unhalt_halted", 16'(bus.HALTED), 16'h0);
    chk("unhalt_ir", 16'(bus.IR), 16'h00);
    chk("unhalt_ret", bus.RETIRED, 16'h0000);

    // Reset in the middle of an extended phase
    drive(1'b1, EN_D, 1'b0, 8'hCF, 1'b0);
    tick();
    drive(1'b1, EX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("rstx_s8", 16'(bus.STATE), 16'h8);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("rstx_state", 16'(bus.STATE), 16'h0);
    chk("rstx_busy", 16'(bus.EXT_BUSY), 16'h0);
    chk("rstx_ir", 16'(bus.IR), 16'h00);

    // RETIRED wraps after 65536 ENDs
    drive(1'b1, EN_D, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 65535; i++) tick();
    chk("wrap_ffff", bus.RETIRED, 16'hFFFF);
    tick();
    chk("wrap_zero", bus.RETIRED, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spc700_seq.md
# spc700_seq

Instruction-state sequencer for the SPC700 core. Each enabled cycle it advances the (IR, STATE) pair that indexes the microcode decoder, and it interprets the decoder's stateCtrl field. It also implements the extended MUL/DIV iteration phase (STATE[3]=1) and the STOP/SLEEP halt. It sits between the bus interface, which supplies opcode bytes, and the microcode decoder, which consumes IR/STATE.

## Interface
Parameters:
- RST_IR, 8'h00 — opcode loaded into IR at reset.
- MUL_OP, 8'hCF — opcode that uses the 4-cycle extended phase.
- DIV_OP, 8'h9E — opcode that uses the 8-cycle extended phase.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- EN  in  1  clock enable; all state holds when 0.
- STATE_CTRL  in  2  stateCtrl of the microinstruction for the current (IR, STATE): 0 NEXT, 1 END, 2 BRANCH, 3 EXT.
- COND  in  1  branch condition for the current cycle; sampled only when STATE_CTRL=2.
- DBUS  in  8  data bus; carries the next opcode on the cycle LAST_CYCLE=1.
- HALT_REQ  in  1  STOP/SLEEP request from the datapath.
- IR  out  8  current opcode (registered).
- STATE  out  4  current microstep; bit 3 = extended phase (registered).
- LAST_CYCLE  out  1  combinational; this is the final cycle of the instruction and the opcode fetch occurs.
- EXT_BUSY  out  1  registered; the extended phase is active.
- HALTED  out  1  registered; the core is stopped.
- RETIRED  out  16  count of retired instructions; wraps modulo 2^16.

## Operation
- Three-state FSM: RUN, EXT, HALT. Reset puts it in RUN.
- Reset values: IR=RST_IR, STATE=0, EXT_BUSY=0, HALTED=0, RETIRED=0, internal ext counter=0, saved step=0.
- All transitions below require EN=1. HALT_REQ takes priority over STATE_CTRL.
- RUN, HALT_REQ=1: go to HALT. IR and STATE freeze. HALTED=1 on the next cycle. Only reset leaves HALT.
- RUN, NEXT: STATE[2:0]+1.
  - If STATE[2:0]=7, NEXT is treated as END; there is no wrap into a new step.
- RUN, END: IR<=DBUS, STATE<=0, RETIRED+1.
- RUN, BRANCH: COND=1 gives NEXT; COND=0 gives END.
- RUN, EXT:
  - If IR=MUL_OP or DIV_OP: go to EXT. Save STATE[2:0], set STATE<=4'h8, counter<=0, EXT_BUSY<=1.
  - Any other IR: treated as NEXT.
- EXT: STATE_CTRL and COND are ignored. Each cycle the counter increments and STATE<={1'b1, counter[1:0]} of the incremented value.
  - MUL: 4 EXT cycles (STATE 8,9,10,11).
  - DIV: 8 EXT cycles (8,9,10,11,8,9,10,11).
  - On the last EXT cycle: STATE<={1'b0, saved+1}, EXT_BUSY<=0, FSM returns to RUN so the microcode can perform writeback.
- LAST_CYCLE = EN & RUN & !HALT_REQ & (END | BRANCH&!COND | NEXT&STATE[2:0]=7).

## Timing
- IR/STATE change on the CLK edge of an enabled cycle. The decoder sees the new index the same edge.
- Opcode fetch has zero-latency capture: DBUS is sampled on the edge where LAST_CYCLE=1.
- Extended-phase cycle counts: MUL total = pre-EXT steps + 4 + post steps; DIV = pre-EXT steps + 8 + post steps.
- EN=0 mid-EXT freezes the counter; the phase resumes exactly where it stopped.
- HALT_REQ during EXT is ignored until the FSM is back in RUN.
- Reset mid-EXT or in HALT: all reset values apply on the next edge.
- RETIRED increments only on END-type transitions, never in HALT or EXT.

## Structure
- Shared spc700 package gains:
  - StateCtrl_t enum: NEXT, END, BRANCH, EXT.
  - SeqState_t enum: RUN, EXT, HALT.
  - Constants EXT_LEN_MUL=4, EXT_LEN_DIV=8.
- Single module, no sub-modules. The ext counter is 3 bits, local.

## Test plan
- Reset, then IR=00, STATE=0, RETIRED=0. Apply END with DBUS=E8 -> IR=E8, STATE=0, RETIRED=1, LAST_CYCLE high for exactly that cycle.
- IR=F0, BRANCH at STATE=1 with COND=0 -> next IR=DBUS, STATE=0. Same with COND=1 -> STATE=2, IR unchanged.
- IR=CF, EXT at STATE=2 -> STATE sequence 8,9,10,11,3, EXT_BUSY high for 4 cycles. With IR=9E -> 8..11,8..11,3, EXT_BUSY high for 8 cycles.
- EXT applied with IR=BC at STATE=1 -> STATE=2, EXT_BUSY stays 0.
- HALT_REQ together with END -> HALTED=1, IR unchanged; further END/EN pulses have no effect; RST_N low -> HALTED=0, IR=00.
- EN low for 3 cycles in the middle of DIV EXT (at STATE=10) -> STATE held at 10, then resumes 11,8,... for a total of 8 EXT cycles. Separately, 65536 ENDs -> RETIRED wraps to 0.
